decoder2to4_stream: RTL and testbench

- Clocked 2-to-4 decoder. It is the receive-side counterpart of the team's 4-to-2 encoder: it turns a 2-bit code back into a one-hot 4-bit line vector.
- Codes enter over a valid/ready handshake and are held in a 2-entry skid buffer.
- Decoded words leave over a second valid/ready handshake.
- Per-line saturating transfer counters give debug visibility. The block sits between the encoder stage and downstream consumers that may stall.

---
 rtl/decoder2to4_stream.sv | 105 ++++++++++
 tb/tb_decoder2to4_stream.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder2to4_stream.sv
// Clocked 2-to-4 decoder with valid/ready input and output handshakes.
// Entries pass through a 2-entry skid buffer. Each output line has a saturating transfer counter.
module decoder2to4_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_onehot,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_clr,
  output logic [3:0]       cnt_sat
);

  logic [3:0]       head_q;
  logic [3:0]       tail_q;
  logic [1:0]       occ_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       sat_q;

  logic       accept;
  logic       xfer;
  logic [3:0] in_word;
  logic [1:0] occ_next;

  assign in_word   = in_en ? (4'b0001 << in_code) : 4'b0000;
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    occ_next = occ_q;
    case ({accept, xfer})
      2'b10:   occ_next = occ_q + 2'd1;
      2'b01:   occ_next = occ_q - 2'd1;
      default: occ_next = occ_q;
    endcase
  end

  // tail_q is kept at zero whenever it is unused, so shifting it into the head
  // also clears the head when the buffer empties.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= 4'b0000;
      tail_q     <= 4'b0000;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      occ_q      <= occ_next;
      in_ready_q <= (occ_next != 2'd2);
      case ({accept, xfer})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= in_word;
          else               tail_q <= in_word;
        end
        2'b01: begin
          head_q <= tail_q;
          tail_q <= 4'b0000;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= in_word;
          end else begin
            head_q <= in_word;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so giving it an async reset is cheap and correct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      sat_q <= 4'b0000;
    end else if (cnt_clr) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      sat_q <= 4'b0000;
    end else if (xfer) begin
      for (int k = 0; k < 4; k++) begin
        if (head_q[k]) begin
          if (&cnt_q[k]) sat_q[k]    <= 1'b1;
          else           cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_onehot = head_q;
  assign cnt_value  = cnt_q[cnt_sel];
  assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_decoder2to4_stream.sv
// Bench for decoder2to4_stream. Directed vectors push their expected words into a queue.
// A monitor process pops the queue and compares on every output transfer.
module tb_decoder2to4_stream;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_code = 2'd0;
  logic             in_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_onehot;
  logic [1:0]       cnt_sel = 2'd0;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_clr = 1'b0;
  logic [3:0]       cnt_sat;

  int n_vec  = 0;
  int n_fail = 0;
  logic [3:0] sb_q [$];

  decoder2to4_stream #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .cnt_sel    (cnt_sel),
    .cnt_value  (cnt_value),
    .cnt_clr    (cnt_clr),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one entry on the input until it is accepted, then queue its expected word.
  task automatic send(input logic [1:0] code, input logic en, input logic [3:0] exp);
    logic accepted = 1'b0;
    in_valid = 1'b1;
    in_code  = code;
    in_en    = en;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(exp);
        accepted = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Monitor: inputs only change just after posedge, so a handshake seen at negedge is the transfer of the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 32'(out_onehot), 32'hdead);
        end else begin
          check("out_word", 32'(out_onehot), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_onehot", 32'(out_onehot), 32'd0);
    check("rst_cnt_value", 32'(cnt_value), 32'd0);
    check("rst_cnt_sat", 32'(cnt_sat), 32'd0);
    tick();
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // Basic decode with one-cycle latency
    out_ready = 1'b1;
    send(2'd0, 1'b1, 4'b0001);
    check("lat_word0", 32'(out_onehot), 32'b0001);
    check("lat_valid0", 32'(out_valid), 32'd1);
    send(2'd1, 1'b1, 4'b0010);
    check("lat_word1", 32'(out_onehot), 32'b0010);
    send(2'd2, 1'b1, 4'b0100);
    check("lat_word2", 32'(out_onehot), 32'b0100);
    send(2'd3, 1'b1, 4'b1000);
    check("lat_word3", 32'(out_onehot), 32'b1000);
    tick();
    check("basic_drained", 32'(out_valid), 32'd0);
    cnt_sel = 2'd2;
    #1 check("basic_cnt2", 32'(cnt_value), 32'd1);

    // Enable low yields an all-zero word that still transfers
    clear_counters();
    send(2'd3, 1'b0, 4'b0000);
    check("en_low_word", 32'(out_onehot), 32'b0000);
    check("en_low_valid", 32'(out_valid), 32'd1);
    send(2'd3, 1'b1, 4'b1000);
    tick();
    cnt_sel = 2'd3;
    #1 check("en_cnt3", 32'(cnt_value), 32'd1);
    cnt_sel = 2'd0;
    #1 check("en_cnt0", 32'(cnt_value), 32'd0);

    // Backpressure: buffer fills at two, third code waits upstream
    out_ready = 1'b0;
    send(2'd1, 1'b1, 4'b0010);
    send(2'd2, 1'b1, 4'b0100);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", 32'(out_onehot), 32'b0010);
    in_valid = 1'b1;
    in_code  = 2'd3;
    in_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_head", 32'(out_onehot), 32'b0010);
    end
    out_ready = 1'b1;
    #1 check("full_no_comb_ready", 32'(in_ready), 32'd0);
    tick();
    check("reopen_in_ready", 32'(in_ready), 32'd1);
    check("reopen_head", 32'(out_onehot), 32'b0100);
    send(2'd3, 1'b1, 4'b1000);
    check("bp_last_head", 32'(out_onehot), 32'b1000);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous accept and transfer at occupancy 1
    out_ready = 1'b0;
    send(2'd0, 1'b1, 4'b0001);
    out_ready = 1'b1;
    send(2'd2, 1'b1, 4'b0100);
    check("sim_head", 32'(out_onehot), 32'b0100);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("sim_empty_valid", 32'(out_valid), 32'd0);
    check("sim_empty_word", 32'(out_onehot), 32'd0);

    // Saturation and clear priority
    clear_counters();
    for (int i = 0; i < 5; i++) send(2'd0, 1'b1, 4'b0001);
    tick();
    cnt_sel = 2'd0;
    #1 check("sat_cnt0", 32'(cnt_value), 32'd3);
    check("sat_flags", 32'(cnt_sat), 32'b0001);
    send(2'd0, 1'b1, 4'b0001);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt0", 32'(cnt_value), 32'd0);
    check("clr_flags", 32'(cnt_sat), 32'b0000);
    check("clr_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with a full buffer
    send(2'd3, 1'b1, 4'b1000);
    tick();
    out_ready = 1'b0;
    send(2'd1, 1'b1, 4'b0010);
    send(2'd2, 1'b1, 4'b0100);
    cnt_sel = 2'd3;
    #1 check("pre_rst_cnt3", 32'(cnt_value), 32'd1);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_onehot", 32'(out_onehot), 32'd0);
    check("mid_rst_cnt3", 32'(cnt_value), 32'd0);
    sb_q.delete();
    out_ready = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
